// File: rtl/mem_wb_stage_pkg.sv
// Shared load/store encodings for the MEM and WB stages, plus the misaligned-load rule.
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10
    } mem_size_e;

    // Byte loads can never be misaligned; only halfword and word loads are checked.
    function automatic logic load_misaligned(logic mem_to_reg, logic [2:0] funct3, logic [1:0] addr);
        logic half_bad;
        logic word_bad;
        half_bad = ((funct3 == LOAD_LH) || (funct3 == LOAD_LHU)) && addr[0];
        word_bad = (funct3 == LOAD_LW) && (addr != 2'b00);
        return mem_to_reg && (half_bad || word_bad);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side inputs, stall/flush control, data-memory read data and WB outputs.
interface mem_wb_stage_if #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
);
    logic                 stall_i;
    logic                 flush_i;
    logic                 mem_valid_i;
    logic                 mem_reg_write_i;
    logic                 mem_mem_to_reg_i;
    logic [4:0]           mem_rd_i;
    logic [XLEN-1:0]      mem_alu_result_i;
    logic [2:0]           mem_load_funct3_i;
    logic [XLEN-1:0]      dmem_read_data_i;
    logic                 wb_valid_o;
    logic                 wb_reg_write_o;
    logic [4:0]           wb_rd_o;
    logic [XLEN-1:0]      wb_write_data_o;
    logic                 wb_load_misaligned_o;
    logic [INSTRET_W-1:0] instret_o;

    modport master (
        output stall_i, flush_i, mem_valid_i, mem_reg_write_i, mem_mem_to_reg_i,
               mem_rd_i, mem_alu_result_i, mem_load_funct3_i, dmem_read_data_i,
        input  wb_valid_o, wb_reg_write_o, wb_rd_o, wb_write_data_o,
               wb_load_misaligned_o, instret_o
    );

    modport slave (
        input  stall_i, flush_i, mem_valid_i, mem_reg_write_i, mem_mem_to_reg_i,
               mem_rd_i, mem_alu_result_i, mem_load_funct3_i, dmem_read_data_i,
        output wb_valid_o, wb_reg_write_o, wb_rd_o, wb_write_data_o,
               wb_load_misaligned_o, instret_o
    );
endinterface

// File: rtl/mem_wb_stage_load_formatter.sv
// Extracts and extends the addressed byte/halfword of a loaded word; combinational only.
module load_formatter
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] formatted
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            LOAD_LB:  formatted = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LOAD_LBU: formatted = {{(XLEN-8){1'b0}}, byte_lane};
            LOAD_LH:  formatted = {{(XLEN-16){half_lane[15]}}, half_lane};
            LOAD_LHU: formatted = {{(XLEN-16){1'b0}}, half_lane};
            default:  formatted = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures MEM results, formats load data in WB, counts retirements.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);

    logic                 valid_q;
    logic                 reg_write_q;
    logic                 mem_to_reg_q;
    logic [4:0]           rd_q;
    logic [XLEN-1:0]      alu_q;
    logic [2:0]           funct3_q;
    logic                 misaligned_q;
    logic                 hold_valid_q;
    logic [XLEN-1:0]      hold_q;
    logic [INSTRET_W-1:0] instret_q;
    logic [XLEN-1:0]      formatted;

    // Flush wins over stall so a bubble can be inserted even while WB is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_q        <= '0;
            funct3_q     <= 3'b000;
            misaligned_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (!bus.stall_i) begin
            valid_q      <= bus.mem_valid_i;
            reg_write_q  <= bus.mem_reg_write_i;
            mem_to_reg_q <= bus.mem_mem_to_reg_i;
            rd_q         <= bus.mem_rd_i;
            alu_q        <= bus.mem_alu_result_i;
            funct3_q     <= bus.mem_load_funct3_i;
            misaligned_q <= load_misaligned(bus.mem_mem_to_reg_i, bus.mem_load_funct3_i,
                                            bus.mem_alu_result_i[1:0]);
        end
    end

    // The SRAM output is only trustworthy in the first stalled cycle, so freeze it there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (bus.stall_i) begin
            if (!hold_valid_q) begin
                hold_q       <= formatted;
                hold_valid_q <= 1'b1;
            end
        end else begin
            hold_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (valid_q && !misaligned_q && !bus.stall_i) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    load_formatter #(
        .XLEN (XLEN)
    ) u_load_formatter (
        .word      (bus.dmem_read_data_i),
        .offset    (alu_q[1:0]),
        .funct3    (funct3_q),
        .formatted (formatted)
    );

    assign bus.wb_valid_o           = valid_q;
    assign bus.wb_reg_write_o       = valid_q & reg_write_q & ~misaligned_q & (rd_q != 5'd0);
    assign bus.wb_rd_o              = rd_q;
    assign bus.wb_write_data_o      = mem_to_reg_q ? (hold_valid_q ? hold_q : formatted) : alu_q;
    assign bus.wb_load_misaligned_o = valid_q & misaligned_q;
    assign bus.instret_o            = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed corner cases followed by randomized traffic.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit        stall;
        bit        flush;
        bit        valid;
        bit        rw;
        bit        m2r;
        bit [4:0]  rd;
        bit [31:0] addr;
        bit [2:0]  f3;
        bit [31:0] dmem;
    } stim_t;

    typedef struct {
        bit          chk_all;
        bit          valid;
        bit          rw;
        bit [4:0]    rd;
        bit [31:0]   data;
        bit          mis;
        bit [63:0]   instret;
        string       tag;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: what the WB stage is holding, described in architectural terms.
    bit              m_valid, m_rw, m_m2r, m_mis, m_held;
    bit [4:0]        m_rd;
    bit [31:0]       m_addr, m_held_val;
    bit [2:0]        m_f3;
    longint unsigned m_instret;

    function automatic stim_t mk(bit stall, bit flush, bit valid, bit rw, bit m2r, bit [4:0] rd,
                                 bit [31:0] addr, bit [2:0] f3, bit [31:0] dmem);
        stim_t s;
        s.stall = stall; s.flush = flush; s.valid = valid; s.rw = rw; s.m2r = m2r;
        s.rd = rd; s.addr = addr; s.f3 = f3; s.dmem = dmem;
        return s;
    endfunction

    function automatic bit [31:0] ref_format(bit [31:0] word, bit [31:0] addr, bit [2:0] f3);
        int unsigned off = addr % 4;
        int unsigned b   = (word >> (8 * off)) % 256;
        int unsigned h   = (word >> (16 * (off / 2))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic bit ref_misaligned(bit m2r, bit [2:0] f3, bit [31:0] addr);
        if (!m2r) return 1'b0;
        if ((f3 == 3'b001 || f3 == 3'b101) && (addr % 2 == 1)) return 1'b1;
        if (f3 == 3'b010 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_mis = 0; m_held = 0;
        m_rd = 0; m_addr = 0; m_held_val = 0; m_f3 = 0; m_instret = 0;
    endfunction

    task automatic cmp(string name, string tag, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s (%s): got %0h, expected %0h", name, tag, act, expv);
        end
    endtask

    task automatic checkOutput(exp_t e);
        cmp("wb_valid", e.tag, 64'(bus.wb_valid_o), 64'(e.valid));
        cmp("wb_reg_write", e.tag, 64'(bus.wb_reg_write_o), 64'(e.rw));
        cmp("wb_load_misaligned", e.tag, 64'(bus.wb_load_misaligned_o), 64'(e.mis));
        cmp("instret", e.tag, bus.instret_o, e.instret);
        if (e.chk_all || e.valid) begin
            cmp("wb_rd", e.tag, 64'(bus.wb_rd_o), 64'(e.rd));
            cmp("wb_write_data", e.tag, 64'(bus.wb_write_data_o), 64'(e.data));
        end
    endtask

    // One pipeline cycle: drive MEM inputs, predict this cycle's WB outputs, then advance the model.
    task automatic applyStimulus(stim_t s, string tag);
        exp_t      e;
        bit [31:0] fmt;
        bus.stall_i           = s.stall;
        bus.flush_i           = s.flush;
        bus.mem_valid_i       = s.valid;
        bus.mem_reg_write_i   = s.rw;
        bus.mem_mem_to_reg_i  = s.m2r;
        bus.mem_rd_i          = s.rd;
        bus.mem_alu_result_i  = s.addr;
        bus.mem_load_funct3_i = s.f3;
        bus.dmem_read_data_i  = s.dmem;

        fmt       = ref_format(s.dmem, m_addr, m_f3);
        e.chk_all = 1'b0;
        e.valid   = m_valid;
        e.rw      = m_valid && m_rw && !m_mis && (m_rd != 0);
        e.rd      = m_rd;
        e.data    = m_m2r ? (m_held ? m_held_val : fmt) : m_addr;
        e.mis     = m_valid && m_mis;
        e.instret = m_instret;
        e.tag     = tag;
        expq.push_back(e);

        @(posedge clk);
        if (s.stall) begin
            if (!m_held) begin
                m_held_val = fmt;
                m_held     = 1'b1;
            end
        end else begin
            m_held = 1'b0;
        end
        if (m_valid && !m_mis && !s.stall) m_instret++;
        if (s.flush) begin
            m_valid = 0; m_rw = 0; m_mis = 0;
        end else if (!s.stall) begin
            m_valid = s.valid; m_rw = s.rw; m_m2r = s.m2r; m_rd = s.rd;
            m_addr = s.addr; m_f3 = s.f3;
            m_mis = ref_misaligned(s.m2r, s.f3, s.addr);
        end
        #1;
    endtask

    // Asserts reset between edges; every output must read zero before the next edge.
    task automatic resetMidCycle(string tag);
        exp_t e;
        rst_n = 1'b0;
        model_reset();
        e.chk_all = 1'b1; e.valid = 0; e.rw = 0; e.rd = 0; e.data = 0;
        e.mis = 0; e.instret = 0; e.tag = tag;
        expq.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        bit [2:0] f3_pick;
        bus.stall_i = 0; bus.flush_i = 0; bus.mem_valid_i = 0; bus.mem_reg_write_i = 0;
        bus.mem_mem_to_reg_i = 0; bus.mem_rd_i = 0; bus.mem_alu_result_i = 0;
        bus.mem_load_funct3_i = 0; bus.dmem_read_data_i = 0;
        model_reset();
        @(posedge clk);
        #1;
        resetMidCycle("power_on_reset");

        // Reach instret = 5 with a valid instruction sitting in WB, then reset mid-cycle.
        for (int i = 0; i < 6; i++)
            applyStimulus(mk(0, 0, 1, 1, 0, 5'(i + 1), 32'(i * 16), 3'b010, $urandom), "fill");
        resetMidCycle("reset_mid_op");

        applyStimulus(mk(0, 0, 1, 1, 0, 7, 32'hDEADBEEF, 3'b010, $urandom), "alu_r7");
        applyStimulus(mk(0, 0, 1, 1, 0, 0, 32'hDEADBEEF, 3'b010, $urandom), "alu_x0");

        applyStimulus(mk(0, 0, 1, 1, 1, 10, 32'h103, 3'b000, $urandom), "lb_issue");
        applyStimulus(mk(0, 0, 1, 1, 1, 11, 32'h103, 3'b100, 32'h80FF1234), "lb");
        applyStimulus(mk(0, 0, 1, 1, 1, 12, 32'h102, 3'b001, 32'h80FF1234), "lbu");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 32'h0, 3'b000, 32'h80010000), "lh");

        applyStimulus(mk(0, 0, 1, 1, 1, 5, 32'h101, 3'b101, $urandom), "lhu_mis_issue");
        applyStimulus(mk(0, 0, 1, 1, 1, 6, 32'h104, 3'b010, $urandom), "lhu_misaligned");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 32'h0, 3'b000, 32'h0BADF00D), "lw_aligned");

        applyStimulus(mk(0, 0, 1, 1, 1, 9, 32'h200, 3'b010, $urandom), "stall_issue");
        applyStimulus(mk(1, 0, 1, 1, 1, 13, 32'h300, 3'b010, 32'h11223344), "stall_1");
        applyStimulus(mk(1, 0, 1, 1, 1, 13, 32'h300, 3'b010, 32'hAAAAAAAA), "stall_2");
        applyStimulus(mk(1, 0, 1, 1, 1, 13, 32'h300, 3'b010, 32'hAAAAAAAA), "stall_3");
        applyStimulus(mk(0, 0, 1, 1, 1, 13, 32'h300, 3'b010, 32'hAAAAAAAA), "stall_release");
        applyStimulus(mk(0, 0, 1, 1, 0, 3, 32'h1234, 3'b010, $urandom), "after_stall");

        applyStimulus(mk(1, 1, 1, 1, 0, 4, 32'h5555, 3'b010, $urandom), "flush_stall");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 32'h0, 3'b000, $urandom), "post_flush");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 32'h0, 3'b000, $urandom), "idle");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) resetMidCycle("random_reset");
            case ($urandom_range(0, 9))
                0, 1:    f3_pick = 3'b000;
                2:       f3_pick = 3'b001;
                3, 4, 5: f3_pick = 3'b010;
                6:       f3_pick = 3'b100;
                7:       f3_pick = 3'b101;
                default: f3_pick = 3'($urandom);
            endcase
            applyStimulus(mk($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                             $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0,
                             $urandom_range(0, 1) == 1, 5'($urandom), $urandom, f3_pick,
                             $urandom), "random");
        end

        repeat (2) @(negedge clk);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register for the 5-stage pipeline.
- Captures MEM-stage control and ALU result, then formats the data-memory load word into the register-file write value.
- Data memory returns read data one cycle after the address is presented, so formatting happens in the WB cycle.
- Also flags misaligned loads, holds load data across stalls, and keeps the retired-instruction counter.

Parameters:
XLEN, 32, datapath width
INSTRET_W, 64, retired-instruction counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hold WB register contents
flush_i  input  1  replace incoming MEM instruction with bubble
mem_valid_i  input  1  MEM stage holds a real instruction
mem_reg_write_i  input  1  instruction writes rd
mem_mem_to_reg_i  input  1  1 = write-back from load data, 0 = from ALU result
mem_rd_i  input  5  destination register
mem_alu_result_i  input  XLEN  ALU result / load address
mem_load_funct3_i  input  3  load type (LB/LH/LW/LBU/LHU)
dmem_read_data_i  input  XLEN  word from data memory, valid the cycle after address
wb_valid_o  output  1  WB holds a real instruction
wb_reg_write_o  output  1  register-file write enable
wb_rd_o  output  5  register-file write address
wb_write_data_o  output  XLEN  register-file write data (also the forwarding source)
wb_load_misaligned_o  output  1  WB instruction is a misaligned load
instret_o  output  INSTRET_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset: valid_q, reg_write_q, mem_to_reg_q, rd_q, alu_q, funct3_q, misaligned_q, hold_valid_q, hold_q, instret all 0.
  - Reset values of outputs: wb_write_data_o = 0 (ALU path of zero), all other outputs 0.
  - Reset mid-stall clears the hold buffer.
- Register update at each rising edge, in priority order:
  - flush_i = 1: valid_q = 0, reg_write_q = 0, misaligned_q = 0; other fields don't-care.
  - Else stall_i = 1: all fields hold.
  - Else: capture all mem_* inputs.
  - Flush outranks stall.
- Misaligned detection, registered at capture:
  - Applies only to loads (mem_to_reg = 1).
  - LH/LHU with addr[0] = 1 is misaligned.
  - LW with addr[1:0] != 0 is misaligned.
- Latency: one cycle from MEM inputs to WB outputs.
- Load formatting (combinational, WB cycle), with off = alu_q[1:0]:
  - LB = sign-extended byte[off]; LBU = zero-extended byte[off].
  - LH = sign-extended half[off[1]]; LHU = zero-extended half[off[1]].
  - LW, and any other funct3, = the full word.
- Stall hold buffer:
  - While a stall is in progress, the SRAM output may change, so the formatted load value is captured once.
  - At an edge with stall_i = 1 and hold_valid_q = 0: hold_q = formatted load value, hold_valid_q = 1.
  - At an edge with stall_i = 0: hold_valid_q = 0.
- Write-data select:
  - wb_write_data_o = mem_to_reg_q ? (hold_valid_q ? hold_q : formatted) : alu_q.
- Output gating:
  - wb_reg_write_o = valid_q & reg_write_q & ~misaligned_q & (rd_q != 0).
  - wb_load_misaligned_o = valid_q & misaligned_q.
- instret counter:
  - Increments at an edge where valid_q = 1, misaligned_q = 0, and stall_i = 0 (instruction leaves WB).
  - Wraps modulo 2^INSTRET_W.
  - Flushed bubbles and misaligned loads never count.

Decomposition:
- Load funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) go in the shared defines header, next to the MemWrite size encodings, so MEM and WB agree.
- One combinational sub-module, load_formatter: inputs word, offset[1:0], funct3; output formatted XLEN value. Reused by a future load-forwarding path.

Test Plan:
1. Reset mid-operation: assert rst_n = 0 between edges while valid_q = 1 and instret = 5 -> all outputs, including instret_o, are 0 immediately (asynchronously, before the next edge).
2. Sign and zero extension:
   - LB at addr 0x103 with dmem_read_data_i = 0x80FF1234 -> wb_write_data_o = 0xFFFFFF80.
   - LBU at the same address and data -> 0x00000080.
   - LH at addr 0x102 with data 0x80010000 -> 0xFFFF8001.
3. Misaligned load: LHU at addr 0x101 -> wb_load_misaligned_o = 1, wb_reg_write_o = 0, instret unchanged. LW at 0x104 -> flag 0, write occurs.
4. Stall hold: LW returns 0x11223344; stall_i = 1 for 3 cycles while dmem_read_data_i changes to 0xAAAAAAAA -> wb_write_data_o stays 0x11223344, instret does not increment until stall_i drops, then +1.
5. Flush with stall: flush_i = 1 and stall_i = 1 on the same edge with a valid WB instruction -> wb_valid_o = 0, wb_reg_write_o = 0 next cycle, instret unchanged.
6. ALU path and x0:
   - mem_to_reg = 0, alu = 0xDEADBEEF, rd = 7 -> write 0xDEADBEEF to r7.
   - Same with rd = 0 -> wb_reg_write_o = 0, instret still +1.
